// File: rtl/vscale_hasti_sram_slave_pkg.sv
// Shared HASTI constants, data-phase states and byte-lane helper
// for the HASTI SRAM responder.
package vscale_hasti_sram_slave_pkg;

  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE     = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALFWORD = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD     = 3'd2;

  typedef enum logic [2:0] {
    DP_IDLE = 3'd0,
    DP_WAIT = 3'd1,
    DP_LAST = 3'd2,
    DP_ERR1 = 3'd3,
    DP_ERR2 = 3'd4
  } dp_state_t;

  function automatic logic [3:0] byte_en(
    input logic [HASTI_SIZE_WIDTH-1:0] size,
    input logic [1:0]                  a
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (size == HASTI_SIZE_BYTE):     be = 4'b0001 << a;
      (size == HASTI_SIZE_HALFWORD): be = 4'b0011 << a;
      default: ;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/vscale_sram_1rw.sv
// Word-addressed single-port SRAM: byte-enabled synchronous write,
// combinational read. Contents are intentionally not reset.
module vscale_sram_1rw #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            wbe,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wbe[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// HASTI (AHB-Lite) responder backed by an internal SRAM, with
// configurable wait states and two-cycle ERROR for illegal transfers.
module vscale_hasti_sram_slave
  import vscale_hasti_sram_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         hsel,
  input  logic [31:0]                  haddr,
  input  logic                         hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] hburst,
  input  logic                         hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic [31:0]                  hwdata,
  output logic [31:0]                  hrdata,
  output logic                         hready,
  output logic                         hresp
);

  localparam logic [3:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dp_state_t state_q;
  dp_state_t state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic [ADDR_WIDTH+1:0]       addr_q;
  logic                        write_q;
  logic [HASTI_SIZE_WIDTH-1:0] size_q;

  logic        rdy;
  logic        resp;
  logic        accept;
  logic        size_ok;
  logic        align_ok;
  logic        range_ok;
  logic        legal;
  logic [3:0]  wbe;
  logic [31:0] sram_rdata;

  // Burst, lock and protection attributes carry no meaning here.
  logic unused_attrs;
  assign unused_attrs = ^{hburst, hmastlock, hprot, htrans[0]};

  assign accept = hsel & htrans[1] & rdy;

  assign size_ok  = (hsize <= HASTI_SIZE_WORD);
  assign range_ok =
    (((haddr ^ BASE_ADDR) >> (ADDR_WIDTH + 2)) == 32'd0);

  always_comb begin
    align_ok = 1'b1;
    unique case (1'b1)
      (hsize == HASTI_SIZE_HALFWORD): align_ok = ~haddr[0];
      (hsize == HASTI_SIZE_WORD):     align_ok = (haddr[1:0] == 2'b00);
      default: ;
    endcase
  end

  assign legal = size_ok & align_ok & range_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy     = 1'b1;
    resp    = HASTI_RESP_OKAY;
    unique case (state_q)
      DP_WAIT: begin
        rdy = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = DP_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DP_ERR1: begin
        rdy     = 1'b0;
        resp    = HASTI_RESP_ERROR;
        state_d = DP_ERR2;
      end
      DP_ERR2: resp = HASTI_RESP_ERROR;
      default: ;
    endcase
    // Any hready-high cycle may also take the next address phase.
    if (rdy) begin
      state_d = DP_IDLE;
      if (accept) begin
        if (!legal) begin
          state_d = DP_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = DP_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = DP_LAST;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DP_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= HASTI_SIZE_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= haddr[ADDR_WIDTH+1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  assign wbe = (state_q == DP_LAST && write_q)
             ? byte_en(size_q, addr_q[1:0]) : 4'b0000;

  vscale_sram_1rw #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk  (clk),
    .addr (addr_q[ADDR_WIDTH+1:2]),
    .wbe  (wbe),
    .wdata(hwdata),
    .rdata(sram_rdata)
  );

  assign hready = rdy;
  assign hresp  = resp;
  assign hrdata =
    ((state_q == DP_WAIT || state_q == DP_LAST) && !write_q)
    ? sram_rdata : 32'd0;

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Scoreboard bench: zero-wait and three-wait responders driven over
// a shared bus; a negedge monitor checks every data phase.
module tb_vscale_hasti_sram_slave;
  import vscale_hasti_sram_slave_pkg::*;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [1:0]  htrans = '0;
  logic [31:0] hwdata = '0;
  logic [2:0]  hburst = '0;
  logic        hmastlock = 1'b0;
  logic [3:0]  hprot = '0;

  logic [31:0] hrdata0, hrdata1;
  logic        hready0, hready1;
  logic        hresp0, hresp1;
  logic        hsel0, hsel1;
  logic        m_hready, m_hresp;
  logic [31:0] m_hrdata;

  exp_t exp_q[$];
  exp_t cur;
  logic active = 1'b0;
  int   waits = 0;
  int   errors = 0;
  int   checks = 0;

  assign hsel0 = hsel & ~sel;
  assign hsel1 = hsel & sel;
  assign m_hready = sel ? hready1 : hready0;
  assign m_hresp  = sel ? hresp1 : hresp0;
  assign m_hrdata = sel ? hrdata1 : hrdata0;

  vscale_hasti_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .hsel(hsel0), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans),
    .hwdata(hwdata), .hrdata(hrdata0), .hready(hready0),
    .hresp(hresp0)
  );

  vscale_hasti_sram_slave #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .hsel(hsel1), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans),
    .hwdata(hwdata), .hrdata(hrdata1), .hready(hready1),
    .hresp(hresp1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: one data phase at a time, retired on hready high.
  always @(negedge clk) begin
    if (!reset_n) begin
      active = 1'b0;
    end else begin
      if (active) begin
        if (!m_hready) begin
          waits++;
          check("mid_resp", {31'd0, m_hresp}, {31'd0, cur.resp});
        end else begin
          check("resp", {31'd0, m_hresp}, {31'd0, cur.resp});
          check("waits", 32'(waits), 32'(cur.waits));
          if (cur.rd) check("rdata", m_hrdata, cur.data);
          active = 1'b0;
        end
      end else begin
        check("idle", {m_hready, m_hresp, m_hrdata},
              {1'b1, 1'b0, 32'd0});
      end
      if (m_hready && hsel && htrans[1]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          waits = 0;
        end
      end
    end
  end

  task automatic xfer(input logic s, input logic [1:0] tr,
                      input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic [31:0] rexp, input logic err);
    int n;
    exp_t e;
    if (s && tr[1]) begin
      e.rd = ~w;
      e.data = err ? 32'd0 : rexp;
      e.resp = err;
      e.waits = err ? 1 : (sel ? 3 : 0);
      exp_q.push_back(e);
    end
    hsel = s; htrans = tr; haddr = a; hwrite = w; hsize = sz;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_hready && n < 64);
    if (!m_hready) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    hwdata = wd;
    hsel = 1'b0;
    htrans = HASTI_TRANS_IDLE;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz,
                    input logic [31:0] wd, input logic err);
    xfer(1'b1, HASTI_TRANS_NONSEQ, a, 1'b1, sz, wd, 32'd0, err);
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] sz,
                    input logic [31:0] rexp, input logic err);
    xfer(1'b1, HASTI_TRANS_SEQ, a, 1'b0, sz, 32'd0, rexp, err);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst0", {hready0, hresp0, hrdata0}, {1'b1, 1'b0, 32'd0});
    check("rst1", {hready1, hresp1, hrdata1}, {1'b1, 1'b0, 32'd0});
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero wait states: back-to-back and byte lanes
    wr(32'h10, HASTI_SIZE_WORD, 32'hDEADBEEF, 1'b0);
    rd(32'h10, HASTI_SIZE_WORD, 32'hDEADBEEF, 1'b0);
    wr(32'h13, HASTI_SIZE_BYTE, 32'hA500_0000, 1'b0);
    rd(32'h10, HASTI_SIZE_WORD, 32'hA5ADBEEF, 1'b0);
    wr(32'h12, HASTI_SIZE_HALFWORD, 32'h1234_0000, 1'b0);
    rd(32'h10, HASTI_SIZE_WORD, 32'h1234BEEF, 1'b0);
    wr(32'h14, HASTI_SIZE_WORD, 32'h0, 1'b0);
    wr(32'h15, HASTI_SIZE_BYTE, 32'h0000_7700, 1'b0);
    wr(32'h14, HASTI_SIZE_HALFWORD, 32'h0000_ABCD, 1'b0);
    rd(32'h14, HASTI_SIZE_WORD, 32'h0000ABCD, 1'b0);

    // Illegal transfers must error and never write
    wr(32'h02, HASTI_SIZE_WORD, 32'hFFFFFFFF, 1'b1);
    wr(32'h1_0010, HASTI_SIZE_WORD, 32'hFFFFFFFF, 1'b1);
    wr(32'h8000_0010, HASTI_SIZE_WORD, 32'hFFFFFFFF, 1'b1);
    wr(32'h10, 3'd3, 32'hFFFFFFFF, 1'b1);
    wr(32'h11, HASTI_SIZE_HALFWORD, 32'hFFFFFFFF, 1'b1);
    rd(32'h02, HASTI_SIZE_WORD, 32'd0, 1'b1);
    rd(32'h10, HASTI_SIZE_WORD, 32'h1234BEEF, 1'b0);

    // No accept on IDLE, BUSY or hsel low
    xfer(1'b1, HASTI_TRANS_IDLE, 32'h10, 1'b1, HASTI_SIZE_WORD,
         32'hFFFFFFFF, 32'd0, 1'b0);
    xfer(1'b1, HASTI_TRANS_BUSY, 32'h10, 1'b1, HASTI_SIZE_WORD,
         32'hFFFFFFFF, 32'd0, 1'b0);
    xfer(1'b0, HASTI_TRANS_NONSEQ, 32'h10, 1'b1, HASTI_SIZE_WORD,
         32'hFFFFFFFF, 32'd0, 1'b0);
    rd(32'h10, HASTI_SIZE_WORD, 32'h1234BEEF, 1'b0);
    drain();

    // Three wait states, pipelined accesses
    sel = 1'b1;
    @(posedge clk);
    #1;
    wr(32'h10, HASTI_SIZE_WORD, 32'hCAFEF00D, 1'b0);
    rd(32'h10, HASTI_SIZE_WORD, 32'hCAFEF00D, 1'b0);
    rd(32'h10, HASTI_SIZE_WORD, 32'hCAFEF00D, 1'b0);
    wr(32'h02, HASTI_SIZE_WORD, 32'hFFFFFFFF, 1'b1);
    rd(32'h10, HASTI_SIZE_WORD, 32'hCAFEF00D, 1'b0);
    wr(32'h20, HASTI_SIZE_WORD, 32'h11112222, 1'b0);
    rd(32'h20, HASTI_SIZE_WORD, 32'h11112222, 1'b0);
    drain();

    // Reset in the middle of a waited write
    wr(32'h20, HASTI_SIZE_WORD, 32'h33334444, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_ready", {31'd0, hready1}, 32'd1);
    check("rst_async_resp", {31'd0, hresp1}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd(32'h20, HASTI_SIZE_WORD, 32'h11112222, 1'b0);
    drain();

    // Zero-wait memory survives reset
    sel = 1'b0;
    @(posedge clk);
    #1;
    rd(32'h10, HASTI_SIZE_WORD, 32'h1234BEEF, 1'b0);
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_active", {31'd0, active}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
